// File: rtl/temp_scan_seq.sv
// Multi-channel ring-oscillator temperature scan sequencer on the 32.768 kHz lfClk.
// Sequences NCH oscillators through one shared counter, averages 2**avgLog2 samples per channel, keeps sticky alarms.
module temp_scan_seq #(
  parameter int WIDTH = 10,
  parameter int NCH   = 4,
  parameter int CHW   = 2,
  parameter int WINW  = 4
) (
  input  logic             lfClk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             contMode,
  input  logic [NCH-1:0]   chEn,
  input  logic [1:0]       avgLog2,
  input  logic [WINW-1:0]  winLen,
  input  logic [WIDTH-1:0] thrHi,
  input  logic             alarmClr,
  input  logic [WIDTH-1:0] count,
  output logic             resetCount,
  output logic [NCH-1:0]   pwrupOsc,
  output logic [CHW-1:0]   chSel,
  output logic             busy,
  output logic             done,
  output logic             cyclesValid,
  output logic [CHW-1:0]   cyclesCh,
  output logic [WIDTH-1:0] cycles,
  output logic [NCH-1:0]   alarm,
  output logic [2:0]       dbgState
);

  // Handshake: start is a level sampled only in IDLE; cyclesValid is a one-cycle
  // pulse with no back-pressure, cycles/cyclesCh are stable while it is high.

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLR     = 3'd1,
    S_PWRUP   = 3'd2,
    S_PWRDWN  = 3'd3,
    S_CAPTURE = 3'd4
  } state_t;

  localparam logic [NCH-1:0]  ONE_HOT0 = 1;
  localparam logic [WINW-1:0] WIN_ONE  = 1;

  state_t             state_q, state_d;
  logic [CHW-1:0]     ch_q, ch_d;
  logic [NCH-1:0]     en_q;
  logic [1:0]         avg_q;
  logic [WINW-1:0]    win_q, win_d;
  logic               cont_q;
  logic [WIDTH-1:0]   thr_q;
  logic [WINW-1:0]    win_cnt_q, win_cnt_d;
  logic [3:0]         samp_q, samp_d, samp_inc, samp_lim;
  logic [WIDTH+2:0]   acc_q, acc_d, acc_sum;
  logic               stop_pend_q, stop_eff;
  logic               latch_cfg;
  logic               res_valid_d;
  logic [WIDTH-1:0]   res_d;
  logic [CHW:0]       first_start, first_en, next_en;
  logic [NCH-1:0]     alarm_set;

  // Lowest enabled channel at or above lo; MSB flags whether one exists.
  function automatic logic [CHW:0] find_from(input logic [NCH-1:0] en, input int lo);
    logic [CHW:0] r;
    r = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (en[i] && (i >= lo)) r = {1'b1, CHW'(i)};
    end
    return r;
  endfunction

  assign dbgState = state_q;

  always_ff @(posedge lfClk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    win_cnt_d   = win_cnt_q;
    samp_d      = samp_q;
    acc_d       = acc_q;
    latch_cfg   = 1'b0;
    res_valid_d = 1'b0;
    res_d       = '0;
    win_d       = (winLen == '0) ? WIN_ONE : winLen;
    stop_eff    = stop_pend_q | stop;
    acc_sum     = acc_q + {3'b000, count};
    samp_inc    = samp_q + 4'd1;
    samp_lim    = 4'd1 << avg_q;
    first_start = find_from(chEn, 0);
    first_en    = find_from(en_q, 0);
    next_en     = find_from(en_q, int'(ch_q) + 1);
    case (state_q)
      S_IDLE: begin
        if (start && first_start[CHW]) begin
          state_d   = S_CLR;
          ch_d      = first_start[CHW-1:0];
          latch_cfg = 1'b1;
          acc_d     = '0;
          samp_d    = '0;
        end
      end
      S_CLR: begin
        state_d   = S_PWRUP;
        win_cnt_d = win_q - WIN_ONE;
      end
      S_PWRUP: begin
        if (win_cnt_q == '0) state_d = S_PWRDWN;
        else                 win_cnt_d = win_cnt_q - WIN_ONE;
      end
      S_PWRDWN: state_d = S_CAPTURE;
      S_CAPTURE: begin
        if (samp_inc < samp_lim) begin
          acc_d   = acc_sum;
          samp_d  = samp_inc;
          state_d = S_CLR;
        end else begin
          res_valid_d = 1'b1;
          res_d       = WIDTH'(acc_sum >> avg_q);
          acc_d       = '0;
          samp_d      = '0;
          if (stop_eff) begin
            state_d = S_IDLE;
          end else if (next_en[CHW]) begin
            ch_d    = next_en[CHW-1:0];
            state_d = S_CLR;
          end else if (cont_q) begin
            ch_d    = first_en[CHW-1:0];
            state_d = S_CLR;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge lfClk or posedge rst) begin
    if (rst) begin
      ch_q        <= '0;
      en_q        <= '0;
      avg_q       <= '0;
      win_q       <= WIN_ONE;
      cont_q      <= 1'b0;
      thr_q       <= '0;
      win_cnt_q   <= '0;
      samp_q      <= '0;
      acc_q       <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      ch_q      <= ch_d;
      win_cnt_q <= win_cnt_d;
      samp_q    <= samp_d;
      acc_q     <= acc_d;
      if (latch_cfg) begin
        en_q   <= chEn;
        avg_q  <= avgLog2;
        win_q  <= win_d;
        cont_q <= contMode;
        thr_q  <= thrHi;
      end
      if (state_d == S_IDLE)                 stop_pend_q <= 1'b0;
      else if (state_q != S_IDLE && stop)    stop_pend_q <= 1'b1;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge lfClk or posedge rst) begin
    if (rst) begin
      resetCount  <= 1'b1;
      pwrupOsc    <= '0;
      chSel       <= '0;
      busy        <= 1'b0;
      done        <= 1'b1;
      cyclesValid <= 1'b0;
      cyclesCh    <= '0;
      cycles      <= '0;
    end else begin
      resetCount  <= (state_d == S_IDLE) || (state_d == S_CLR);
      pwrupOsc    <= (state_d == S_PWRUP) ? (ONE_HOT0 << ch_d) : '0;
      chSel       <= ch_d;
      busy        <= (state_d != S_IDLE);
      done        <= (state_d == S_IDLE);
      cyclesValid <= res_valid_d;
      if (res_valid_d) begin
        cycles   <= res_d;
        cyclesCh <= ch_q;
      end
    end
  end

  // Alarm evaluates the published result; a set in the same cycle as alarmClr survives.
  assign alarm_set = (cyclesValid && (cycles >= thr_q)) ? (ONE_HOT0 << cyclesCh) : '0;

  always_ff @(posedge lfClk or posedge rst) begin
    if (rst) alarm <= '0;
    else     alarm <= (alarmClr ? '0 : alarm) | alarm_set;
  end

endmodule

// File: tb/tb_temp_scan_seq.sv
// Directed bench for temp_scan_seq: cycle n is the interval after edge n-1, start sampled at edge 0.
// Expected values are hand-derived from sample = W+3 cycles and channel = 2**avgLog2 samples.
module tb_temp_scan_seq;
  localparam int WIDTH = 10;
  localparam int NCH   = 4;
  localparam int CHW   = 2;
  localparam int WINW  = 4;

  logic             lfClk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             contMode = 1'b0;
  logic [NCH-1:0]   chEn = '0;
  logic [1:0]       avgLog2 = '0;
  logic [WINW-1:0]  winLen = 4'd1;
  logic [WIDTH-1:0] thrHi = '1;
  logic             alarmClr = 1'b0;
  logic [WIDTH-1:0] count = '0;
  logic             resetCount;
  logic [NCH-1:0]   pwrupOsc;
  logic [CHW-1:0]   chSel;
  logic             busy;
  logic             done;
  logic             cyclesValid;
  logic [CHW-1:0]   cyclesCh;
  logic [WIDTH-1:0] cycles;
  logic [NCH-1:0]   alarm;
  logic [2:0]       dbgState;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int pulse_base;

  temp_scan_seq #(.WIDTH(WIDTH), .NCH(NCH), .CHW(CHW), .WINW(WINW)) dut (
    .lfClk(lfClk), .rst(rst), .start(start), .stop(stop), .contMode(contMode),
    .chEn(chEn), .avgLog2(avgLog2), .winLen(winLen), .thrHi(thrHi),
    .alarmClr(alarmClr), .count(count), .resetCount(resetCount),
    .pwrupOsc(pwrupOsc), .chSel(chSel), .busy(busy), .done(done),
    .cyclesValid(cyclesValid), .cyclesCh(cyclesCh), .cycles(cycles),
    .alarm(alarm), .dbgState(dbgState)
  );

  always #5 lfClk = ~lfClk;

  always @(negedge lfClk) if (cyclesValid === 1'b1) pulse_cnt++;

  task automatic tick();
    @(posedge lfClk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Configure, raise start for one edge; returns in cycle 1 (CLR).
  task automatic launch(input logic [NCH-1:0] en, input logic [1:0] a, input logic [WINW-1:0] wl,
                        input logic cm, input logic [WIDTH-1:0] cnt);
    chEn = en; avgLog2 = a; winLen = wl; contMode = cm; count = cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // 1: reset and idle
    tick_n(2);
    rst = 1'b0;
    tick();
    check("rst_resetCount", resetCount, 1);
    check("rst_done", done, 1);
    check("rst_busy", busy, 0);
    check("rst_pwrup", pwrupOsc, 0);
    check("rst_valid", cyclesValid, 0);
    check("rst_cycles", cycles, 0);
    check("rst_ch", {cyclesCh, chSel}, 0);
    check("rst_alarm", alarm, 0);
    tick_n(20);
    check("idle20_done", done, 1);
    check("idle20_state", dbgState, 0);

    // start with empty mask is ignored
    launch(4'b0000, 2'd0, 4'd1, 1'b0, 10'd5);
    check("emptymask_busy", busy, 0);

    // 2: single channel, single sample
    launch(4'b0100, 2'd0, 4'd1, 1'b0, 10'd300);
    check("t2_c1_resetCount", resetCount, 1);
    check("t2_c1_busy", busy, 1);
    check("t2_c1_chSel", chSel, 2);
    tick();
    check("t2_c2_pwrup", pwrupOsc, 4'b0100);
    check("t2_c2_resetCount", resetCount, 0);
    tick();
    check("t2_c3_pwrup", pwrupOsc, 0);
    tick();
    check("t2_c4_valid", cyclesValid, 0);
    tick();
    check("t2_c5_valid", cyclesValid, 1);
    check("t2_c5_cycles", cycles, 300);
    check("t2_c5_ch", cyclesCh, 2);
    check("t2_c5_done", done, 1);
    tick();
    check("t2_c6_valid", cyclesValid, 0);
    check("t2_c6_hold", cycles, 300);

    // 3: all channels, 4 samples, W=3 -> results every 24 cycles
    pulse_base = pulse_cnt;
    launch(4'b1111, 2'd2, 4'd3, 1'b0, 10'd100);
    for (int ch = 0; ch < 4; ch++) begin
      for (int s = 0; s < 4; s++) begin
        count = 10'(100 + s);
        tick_n(6);
      end
      check("t3_valid", cyclesValid, 1);
      check("t3_cycles", cycles, 101);
      check("t3_ch", cyclesCh, ch);
    end
    check("t3_done", done, 1);
    tick();
    check("t3_pulses", pulse_cnt - pulse_base, 4);

    // continuous wrap on a single channel, then stop
    pulse_base = pulse_cnt;
    launch(4'b0010, 2'd0, 4'd1, 1'b1, 10'd33);
    tick_n(4);
    check("wrap_c5_valid", cyclesValid, 1);
    check("wrap_c5_busy", busy, 1);
    tick_n(4);
    check("wrap_c9_valid", cyclesValid, 1);
    check("wrap_c9_ch", cyclesCh, 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick_n(3);
    check("wrap_c13_valid", cyclesValid, 1);
    check("wrap_c13_done", done, 1);
    tick_n(10);
    check("wrap_pulses", pulse_cnt - pulse_base, 3);
    check("wrap_idle", busy, 0);

    // 4: stop mid channel 0 with channel 3 still pending
    pulse_base = pulse_cnt;
    launch(4'b1001, 2'd1, 4'd2, 1'b1, 10'd50);
    tick_n(3);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    tick_n(6);
    check("t4_valid", cyclesValid, 1);
    check("t4_ch", cyclesCh, 0);
    check("t4_cycles", cycles, 50);
    check("t4_done", done, 1);
    tick_n(20);
    check("t4_pulses", pulse_cnt - pulse_base, 1);
    check("t4_idle", dbgState, 0);

    // 5: alarm threshold, equality, clear vs set
    thrHi = 10'd200;
    launch(4'b0001, 2'd0, 4'd1, 1'b0, 10'd200);
    tick_n(5);
    check("t5_eq_alarm", alarm, 4'b0001);
    launch(4'b0100, 2'd0, 4'd1, 1'b0, 10'd199);
    tick_n(5);
    check("t5_below_alarm", alarm, 4'b0001);
    launch(4'b0010, 2'd0, 4'd1, 1'b0, 10'd250);
    tick_n(4);
    check("t5_res_valid", cyclesValid, 1);
    alarmClr = 1'b1;
    tick();
    alarmClr = 1'b0;
    check("t5_setwins_alarm", alarm, 4'b0010);
    tick_n(2);
    alarmClr = 1'b1;
    tick();
    alarmClr = 1'b0;
    check("t5_clr_alarm", alarm, 0);

    // 6: async reset mid-scan after one sample was accumulated
    launch(4'b0001, 2'd1, 4'd1, 1'b0, 10'd500);
    tick_n(5);
    check("t6_pwrup", pwrupOsc, 4'b0001);
    #2 rst = 1'b1;
    #1;
    check("t6_async_pwrup", pwrupOsc, 0);
    check("t6_async_resetCount", resetCount, 1);
    check("t6_async_busy", busy, 0);
    tick();
    rst = 1'b0;
    tick();
    launch(4'b0001, 2'd1, 4'd0, 1'b0, 10'd60);
    tick();
    check("t6_w0_c2_pwrup", pwrupOsc, 4'b0001);
    tick();
    check("t6_w0_c3_pwrup", pwrupOsc, 0);
    tick_n(5);
    check("t6_c8_valid", cyclesValid, 0);
    check("t6_c8_busy", busy, 1);
    tick();
    check("t6_c9_valid", cyclesValid, 1);
    check("t6_c9_cycles", cycles, 60);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
